fpu_add_norm_round: RTL

Final stage of the FPU single-precision adder: consumes the signed-magnitude sum from the add stage (`sum`, `carry_out`, `sign_out`, `exp_max_out`, `frm_out`). Normalizes it one bit per cycle with a small FSM, rounds per RISC-V `frm`, and packs an IEEE-754 binary32 result with `fflags`. A valid/ready handshake on both sides lets it sit between the add stage and the FPU writeback.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_add_norm_round_if.sv | 24 ++
 rtl/fpu_rounder.sv | 25 ++
 rtl/fpu_add_norm_round.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 adder stages.
package fpu_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } frm_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_t;

  // Exponent arithmetic is carried in 10 bits so overflow past 255 is visible.
  localparam logic [9:0]  EXP_MAX    = 10'd255;
  localparam logic [7:0]  BIAS       = 8'd127;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

endpackage

// File: rtl/fpu_add_norm_round_if.sv
// Handshake and data bundle between the add stage, this normalizer and writeback.
interface fpu_add_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [25:0] sum_in;
  logic        carry_in;
  logic [7:0]  exp_in;
  logic [2:0]  frm_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  modport master (
    output in_valid, sign_in, sum_in, carry_in, exp_in, frm_in, out_ready,
    input  in_ready, out_valid, result, fflags
  );

  modport slave (
    input  in_valid, sign_in, sum_in, carry_in, exp_in, frm_in, out_ready,
    output in_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fpu_rounder.sv
// Round-up decision for RISC-V rounding modes; reserved encodings behave as RNE.
module fpu_rounder
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic [2:0] frm,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       round_up,
  output logic       nx
);

  always_comb begin
    nx = g | s;
    case (frm)
      RTZ:     round_up = 1'b0;
      RDN:     round_up = sign & (g | s);
      RUP:     round_up = ~sign & (g | s);
      RMM:     round_up = g;
      default: round_up = g & (s | lsb);
    endcase
  end

endmodule

// File: rtl/fpu_add_norm_round.sv
// Normalize (one bit per cycle), round and pack the binary32 adder result.
// Define FPU_SUBNORMAL_EN to produce subnormal results instead of flushing them.
module fpu_add_norm_round
  import fpu_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  fpu_add_norm_round_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ALIGN = ST_ALIGN;
  localparam logic [1:0] S_ROUND = ST_ROUND;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]  state_reg;
  logic [26:0] m_reg;
  logic [9:0]  e_reg;
  logic        sign_reg;
  logic [2:0]  frm_reg;
  logic [31:0] result_reg;
  fflags_t     fflags_reg;

  logic        round_up;
  logic        round_nx;
  logic [24:0] sig_sum;
  logic [23:0] sig_rnd;
  logic [9:0]  e_rnd;
  logic        ovf_inf;
  logic [31:0] result_next;
  fflags_t     fflags_next;

  fpu_rounder u_rounder (
    .sign     (sign_reg),
    .frm      (frm_reg),
    .lsb      (m_reg[2]),
    .g        (m_reg[1]),
    .s        (m_reg[0]),
    .round_up (round_up),
    .nx       (round_nx)
  );

  // A carry out of the 24-bit significand renormalizes to 1.0 with e+1.
  always_comb begin
    sig_sum = {1'b0, m_reg[25:2]} + {24'd0, round_up};
    if (sig_sum[24]) begin
      sig_rnd = 24'h80_0000;
      e_rnd   = e_reg + 10'd1;
    end else begin
      sig_rnd = sig_sum[23:0];
      e_rnd   = e_reg;
    end
  end

  always_comb begin
    case (frm_reg)
      RTZ:     ovf_inf = 1'b0;
      RDN:     ovf_inf = sign_reg;
      RUP:     ovf_inf = ~sign_reg;
      default: ovf_inf = 1'b1;
    endcase
  end

  always_comb begin
    result_next = '0;
    fflags_next = '0;
    if (m_reg == '0) begin
      result_next = {(frm_reg == RDN), 31'd0};
`ifndef FPU_SUBNORMAL_EN
    end else if (!m_reg[25]) begin
      result_next    = {sign_reg, 31'd0};
      fflags_next.uf = 1'b1;
      fflags_next.nx = 1'b1;
`endif
    end else if (e_rnd >= EXP_MAX) begin
      result_next    = ovf_inf ? {sign_reg, 8'hFF, 23'd0} : {sign_reg, MAX_FINITE[30:0]};
      fflags_next.of = 1'b1;
      fflags_next.nx = 1'b1;
    end else begin
      // Tininess is judged after rounding: a subnormal that rounds up to
      // the smallest normal gets exponent field 1.
      result_next    = {sign_reg, (sig_rnd[23] ? e_rnd[7:0] : 8'd0), sig_rnd[22:0]};
      fflags_next.uf = ~sig_rnd[23] & round_nx;
      fflags_next.nx = round_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg  <= S_IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      sign_reg   <= 1'b0;
      frm_reg    <= '0;
      result_reg <= '0;
      fflags_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_reg <= S_ALIGN;
            sign_reg  <= bus.sign_in;
            frm_reg   <= bus.frm_in;
            e_reg     <= (bus.exp_in == 8'd0) ? 10'd1 : {2'b00, bus.exp_in};
`ifdef FPU_SUBNORMAL_EN
            m_reg     <= {bus.carry_in, bus.sum_in};
`else
            m_reg     <= (bus.exp_in == 8'd0) ? 27'd0 : {bus.carry_in, bus.sum_in};
`endif
          end
        end
        S_ALIGN: begin
          if (m_reg == '0) begin
            state_reg <= S_ROUND;
          end else if (m_reg[26]) begin
            // Right shift keeps the dropped bit in the sticky position.
            m_reg     <= {1'b0, m_reg[26:2], m_reg[1] | m_reg[0]};
            e_reg     <= e_reg + 10'd1;
            state_reg <= S_ROUND;
          end else if (m_reg[25] || e_reg == 10'd1) begin
            state_reg <= S_ROUND;
          end else begin
            m_reg <= {m_reg[25:0], 1'b0};
            e_reg <= e_reg - 10'd1;
          end
        end
        S_ROUND: begin
          result_reg <= result_next;
          fflags_reg <= fflags_next;
          state_reg  <= S_DONE;
        end
        default: begin
          if (bus.out_ready) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.result    = result_reg;
  assign bus.fflags    = fflags_reg;

endmodule
